// File: rtl/ctrl_signal_encoder_if.sv
// Command handshake and control-code bus between a command source and ctrl_signal_encoder.
// The err_count signal exists only when CTRL_ENC_ERR_CNT_EN is defined.
interface ctrl_signal_encoder_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic                 cmd_ready;
  logic [3:0]           control_signal;
  logic                 locked;
  logic                 cmd_err;
`ifdef CTRL_ENC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, control_signal, locked, cmd_err, err_count
  );
  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, control_signal, locked, cmd_err, err_count
  );
`else
  if (ERR_CNT_W < 1) begin : g_bad_width
    $error("ERR_CNT_W must be at least 1");
  end

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, control_signal, locked, cmd_err
  );
  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, control_signal, locked, cmd_err
  );
`endif
endinterface

// File: rtl/ctrl_signal_encoder.sv
// Enable/disable/lock encoder driving the 4-bit control_signal bus, with a post-change settle window.
// Optional saturating rejected-command counter enabled by CTRL_ENC_ERR_CNT_EN.
module ctrl_signal_encoder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_signal_encoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1 || ERR_CNT_W < 1) begin : g_param_check
    $error("SETTLE_CYCLES and ERR_CNT_W must both be at least 1");
  end

  // Enum values equal the emitted codes, so the bus is the state register itself.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EN   = 2'b01,
    ST_DIS  = 2'b10,
    ST_LOCK = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             ready;
  logic             xfer;

  assign ready = (settle_q == '0) || (state_q == ST_LOCK);
  assign xfer  = bus.cmd_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    settle_d = (settle_q != '0) ? settle_q - 1'b1 : '0;

    if (xfer) begin
      if (state_q == ST_LOCK) begin
        err_d = 1'b1;
      end else begin
        unique case (bus.cmd)
          2'b00: state_d = ST_IDLE;
          2'b01: state_d = ST_EN;
          2'b10: state_d = ST_DIS;
          2'b11: begin
            if (state_q == ST_DIS) state_d = ST_LOCK;
            else                   err_d   = 1'b1;
          end
          default: state_d = state_q;
        endcase
      end
    end

    // Only a real code change opens a settle window; same-state commands do not.
    if (state_d != state_q) begin
      settle_d = CNT_W'(SETTLE_CYCLES);
    end

    locked_d = (state_d == ST_LOCK);
  end

  assign bus.cmd_ready      = ready;
  assign bus.control_signal = {2'b00, state_q};
  assign bus.locked         = locked_q;
  assign bus.cmd_err        = err_q;

`ifdef CTRL_ENC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_signal_encoder.sv
// Directed self-checking bench for ctrl_signal_encoder (SETTLE_CYCLES = 4, ERR_CNT_W = 2).
module tb_ctrl_signal_encoder;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned ECW    = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ctrl_signal_encoder_if #(.ERR_CNT_W(ECW)) bus ();

  ctrl_signal_encoder #(
    .SETTLE_CYCLES(SETTLE),
    .ERR_CNT_W    (ECW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] code, input logic lck,
                            input logic rdy, input logic err);
    check_eq({tag, ".code"},  16'(bus.control_signal), 16'(code));
    check_eq({tag, ".lock"},  16'(bus.locked),         16'(lck));
    check_eq({tag, ".ready"}, 16'(bus.cmd_ready),      16'(rdy));
    check_eq({tag, ".err"},   16'(bus.cmd_err),        16'(err));
  endtask

  // Called at a negedge; the transfer happens at the next posedge and the task
  // returns at the following negedge (first cycle after the transfer).
  task automatic send(input logic [1:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;

    @(negedge clk);
    check_outs("in_reset", 4'h0, 1'b0, 1'b1, 1'b0);
`ifdef CTRL_ENC_ERR_CNT_EN
    check_eq("in_reset.cnt", 16'(bus.err_count), 16'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_reset", 4'h0, 1'b0, 1'b1, 1'b0);

    // Enable, then hold valid with cmd 10 through the settle window.
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b01;
    @(negedge clk);
    bus.cmd = 2'b10;
    check_outs("en_c1", 4'h1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= SETTLE; i++) begin
      @(negedge clk);
      check_outs($sformatf("en_settle%0d", i), 4'h1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check_outs("en_ready_again", 4'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_outs("held_dis", 4'h2, 1'b0, 1'b0, 1'b0);
    repeat (SETTLE) @(negedge clk);
    check_outs("dis_settled", 4'h2, 1'b0, 1'b1, 1'b0);

    // Same-state command: no change, no window, no error.
    send(2'b10);
    check_outs("same_dis", 4'h2, 1'b0, 1'b1, 1'b0);

    // DIS -> LOCK; ready stays high in LOCK.
    send(2'b11);
    check_outs("lock", 4'h3, 1'b1, 1'b1, 1'b0);

    // Five back-to-back rejects in LOCK.
    bus.cmd_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.cmd = 2'(k);
      @(negedge clk);
      check_outs($sformatf("rej%0d", k), 4'h3, 1'b1, 1'b1, 1'b1);
`ifdef CTRL_ENC_ERR_CNT_EN
      check_eq($sformatf("rej%0d.cnt", k), 16'(bus.err_count), (k < 3) ? 16'(k) : 16'd3);
`endif
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_outs("rej_done", 4'h3, 1'b1, 1'b1, 1'b0);
`ifdef CTRL_ENC_ERR_CNT_EN
    check_eq("rej_done.cnt", 16'(bus.err_count), 16'd3);
`endif

    // Asynchronous reset between edges while in LOCK.
    #1 rst_n = 1'b0;
    #1 check_outs("rst_in_lock", 4'h0, 1'b0, 1'b1, 1'b0);
`ifdef CTRL_ENC_ERR_CNT_EN
    check_eq("rst_in_lock.cnt", 16'(bus.err_count), 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal lock from IDLE.
    send(2'b11);
    check_outs("idle_lock_rej", 4'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("idle_lock_after", 4'h0, 1'b0, 1'b1, 1'b0);

    // Illegal lock from EN.
    send(2'b01);
    check_outs("en2", 4'h1, 1'b0, 1'b0, 1'b0);
    repeat (SETTLE) @(negedge clk);
    send(2'b11);
    check_outs("en_lock_rej", 4'h1, 1'b0, 1'b1, 1'b1);

    // Release to idle, then reset mid-settle.
    send(2'b00);
    check_outs("release", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_outs("rst_mid_settle", 4'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("final", 4'h0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_signal_encoder.md
# ctrl_signal_encoder

Sequential encoder that drives the 4-bit `control_signal` bus consumed by the enable/lock decoder. It accepts one-hot-free 2-bit commands over a valid/ready handshake and maintains the enable/disable/lock state. It emits only the legal codes 0000, 0001, 0010 and 0011. The lock state is sticky until reset. After each code change, a settle window holds off new commands so downstream logic sees a stable bus.

## Interface
- `SETTLE_CYCLES`, default 4: number of cycles `cmd_ready` stays low after a code change. Legal range is ≥ 1.
- `ERR_CNT_W`, default 8: width of the rejected-command counter (used only with the macro).

Ports:
- `clk` input, 1: single clock; all logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `cmd_valid` input, 1: command present.
- `cmd` input, 2: 00 = release to idle, 01 = enable, 10 = disable, 11 = lock.
- `cmd_ready` output, 1: the encoder can accept a command this cycle.
- `control_signal` output, 4: registered code to the decoder.
- `locked` output, 1: registered; high iff `control_signal` == 0011.
- `cmd_err` output, 1: one-cycle pulse when an accepted command is rejected.
- `err_count` output, `ERR_CNT_W`: saturating count of rejected commands. Present only with `CTRL_ENC_ERR_CNT_EN`.

## Operation
- **Handshake:** a command transfers on a rising edge with `cmd_valid` && `cmd_ready`.
  - `cmd` is sampled only on transfer.
  - Holding `cmd_valid` high while `cmd_ready` is low has no effect.
- **State machine:** states IDLE (code 0000), EN (0001), DIS (0010), LOCK (0011), plus an orthogonal settle counter.
- **IDLE / EN / DIS transitions:**
  - cmd 00 → IDLE.
  - cmd 01 → EN.
  - cmd 10 → DIS.
  - cmd 11 → LOCK only from DIS. From IDLE or EN it is rejected.
- **LOCK:** terminal. Every transferred command is rejected. Only `rst_n` leaves LOCK.
- **Rejected command:** state and code are unchanged, `cmd_err` pulses, and no settle window starts.
- **Same-state command** (e.g. 01 while in EN): accepted, no code change, no settle window, no `cmd_err`.
- **Legal codes only:** `control_signal` never takes any value other than 0000/0001/0010/0011, and bits [3:2] are always 0.
- **Settle window:** on a code change, the settle counter loads `SETTLE_CYCLES` and `cmd_ready` is low while the counter is non-zero. `cmd_ready` is also high in LOCK, so rejects remain observable.
- **Reset values:**
  - `control_signal` = 0000, state IDLE.
  - `locked` = 0, `cmd_err` = 0, `err_count` = 0.
  - Settle counter = 0, so `cmd_ready` = 1.
- **Reset mid-operation:** assertion at any time, including mid-settle or in LOCK, immediately forces the reset values.

## Timing
- **Output latency:** a transfer at edge N makes the new `control_signal` / `locked` visible after edge N, i.e. one cycle of latency. No combinational path from `cmd` to `control_signal`.
- **Settle window timing:** `cmd_ready` is low for cycles N+1 … N+`SETTLE_CYCLES` and high again at cycle N+`SETTLE_CYCLES`+1. The next transfer is possible at the edge ending that cycle.
- **`cmd_err` timing:** high for exactly the one cycle following edge N of the rejected transfer. Back-to-back rejects give back-to-back pulses.
- **`cmd_ready` source:** a function of registered state only, so it does not depend on `cmd_valid` in the same cycle.
- **Reset release:** `cmd_ready` = 1 in the first cycle after `rst_n` deasserts.

## Configuration
- `CTRL_ENC_ERR_CNT_EN` defined:
  - `err_count` port exists.
  - It increments on every `cmd_err` pulse, in the same cycle `cmd_err` is driven.
  - It saturates at 2^`ERR_CNT_W`−1 and clears only on reset.
- Undefined:
  - Port and counter are absent.
  - `cmd_err` behaviour is identical.

## Test plan
- **Reset then enable:** release reset, transfer cmd 01 at edge N.
  - `control_signal` = 0001 from cycle N+1.
  - `cmd_ready` low for 4 cycles, then high.
- **Lock path:** from EN, cmd 10, wait out settle, then cmd 11.
  - `control_signal` 0001 → 0010 → 0011.
  - `locked` = 1.
  - Subsequent cmd 01/10/00 each give a `cmd_err` pulse, and the code stays at 0011.
- **Illegal lock:** from IDLE, cmd 11.
  - `cmd_err` pulses.
  - `control_signal` stays 0000.
  - `cmd_ready` stays 1, with no settle window.
- **Held valid during settle:** after the cmd 01 transfer, keep `cmd_valid` = 1 with cmd 10 throughout the settle window.
  - Transfer occurs only at edge N+`SETTLE_CYCLES`+1.
  - The code becomes 0010 one cycle later.
- **Reset mid-settle / in LOCK:** assert `rst_n` = 0 asynchronously between edges.
  - `control_signal` = 0000, `locked` = 0, `cmd_ready` = 1 immediately, without waiting for a clock edge.
- **With `CTRL_ENC_ERR_CNT_EN` and `ERR_CNT_W` = 2:** issue 5 rejected commands in LOCK.
  - `err_count` goes 1, 2, 3, 3, 3.
